// File: rtl/koios_pe_arbiter_if.sv
// Bus bundle between the NoC requesters, the arbiter and the single PE wrapper.
// slave: arbiter side; master: requester/PE side (testbench).
interface koios_pe_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int AXI_DATAW = 128
);
  logic [NUM_REQ*AXI_DATAW-1:0] req_data;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*4-1:0]         req_dest;
  logic [NUM_REQ*2-1:0]         req_id;
  logic [NUM_REQ-1:0]           req_ready;

  logic [AXI_DATAW-1:0]         rsp_data;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [3:0]                   rsp_dest;
  logic [1:0]                   rsp_id;
  logic                         rsp_err;
  logic [NUM_REQ-1:0]           rsp_ready;

  logic [AXI_DATAW-1:0]         pe_inp_data;
  logic                         pe_inp_valid;
  logic [3:0]                   pe_inp_dest;
  logic [1:0]                   pe_inp_id;
  logic                         pe_inp_ready;

  logic [AXI_DATAW-1:0]         pe_outp_data;
  logic                         pe_outp_valid;
  logic [3:0]                   pe_outp_dest;
  logic [1:0]                   pe_outp_id;
  logic                         pe_outp_ready;

  modport slave (
    input  req_data, req_valid, req_dest, req_id,
    output req_ready,
    output rsp_data, rsp_valid, rsp_dest, rsp_id, rsp_err,
    input  rsp_ready,
    output pe_inp_data, pe_inp_valid, pe_inp_dest, pe_inp_id,
    input  pe_inp_ready,
    input  pe_outp_data, pe_outp_valid, pe_outp_dest, pe_outp_id,
    output pe_outp_ready
  );

  modport master (
    output req_data, req_valid, req_dest, req_id,
    input  req_ready,
    input  rsp_data, rsp_valid, rsp_dest, rsp_id, rsp_err,
    output rsp_ready,
    input  pe_inp_data, pe_inp_valid, pe_inp_dest, pe_inp_id,
    output pe_inp_ready,
    output pe_outp_data, pe_outp_valid, pe_outp_dest, pe_outp_id,
    input  pe_outp_ready
  );
endinterface

// File: rtl/koios_pe_arbiter.sv
// Round-robin arbiter sharing one Koios proxy-PE between NUM_REQ requesters.
// Ports: clk, reset (async, active-low), bus (slave modport: req/rsp/pe),
// busy (state != IDLE), timeout_err (sticky watchdog), err_clr (sync clear).
module koios_pe_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int AXI_DATAW   = 128,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  koios_pe_arbiter_if.slave bus,
  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clr
);
  localparam int LW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RETURN
  } state_e;

  state_e               state_q, state_d;
  logic [LW-1:0]        last_q, owner_q, win;
  logic                 any_v;
  logic [AXI_DATAW-1:0] sel_data;
  logic [3:0]           sel_dest;
  logic [1:0]           sel_id;

  logic [AXI_DATAW-1:0] iss_data_q;
  logic [3:0]           iss_dest_q;
  logic [1:0]           iss_id_q;
  logic [AXI_DATAW-1:0] rsp_data_q;
  logic [3:0]           rsp_dest_q;
  logic [1:0]           rsp_id_q;
  logic                 rsp_err_q;
  logic [CW-1:0]        cnt_q;
  logic                 terr_q;

  logic accept, issue_hs, pe_hit, expire, rsp_hs;

  // Walk offsets from far to near so the closest requester
  // after last_q overwrites any farther candidate.
  always_comb begin
    int idx;
    idx   = 0;
    win   = '0;
    any_v = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.req_valid[LW'(idx)]) begin
        win   = LW'(idx);
        any_v = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_dest = '0;
    sel_id   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == LW'(i)) begin
        sel_data = bus.req_data[i*AXI_DATAW +: AXI_DATAW];
        sel_dest = bus.req_dest[i*4 +: 4];
        sel_id   = bus.req_id[i*2 +: 2];
      end
    end
  end

  assign accept   = (state_q == S_IDLE) && any_v;
  assign issue_hs = (state_q == S_ISSUE) && bus.pe_inp_ready;
  assign pe_hit   = (state_q == S_WAIT) && bus.pe_outp_valid;
  // A result arriving on the expiry cycle takes precedence.
  assign expire   = (state_q == S_WAIT) && !bus.pe_outp_valid &&
                    (cnt_q == CW'(TIMEOUT_CYC - 1));
  assign rsp_hs   = (state_q == S_RETURN) && bus.rsp_ready[owner_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_ISSUE;
      S_ISSUE:  if (issue_hs) state_d = S_WAIT;
      S_WAIT:   if (pe_hit || expire) state_d = S_RETURN;
      S_RETURN: if (rsp_hs) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready     = '0;
    bus.pe_inp_valid  = 1'b0;
    bus.pe_inp_data   = '0;
    bus.pe_inp_dest   = '0;
    bus.pe_inp_id     = '0;
    bus.pe_outp_ready = 1'b0;
    bus.rsp_valid     = '0;
    bus.rsp_data      = '0;
    bus.rsp_dest      = '0;
    bus.rsp_id        = '0;
    bus.rsp_err       = 1'b0;
    busy              = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        bus.req_ready[win] = any_v;
      end
      S_ISSUE: begin
        bus.pe_inp_valid = 1'b1;
        bus.pe_inp_data  = iss_data_q;
        bus.pe_inp_dest  = iss_dest_q;
        bus.pe_inp_id    = iss_id_q;
      end
      S_WAIT: begin
        bus.pe_outp_ready = 1'b1;
      end
      S_RETURN: begin
        bus.rsp_valid[owner_q] = 1'b1;
        bus.rsp_data = rsp_data_q;
        bus.rsp_dest = rsp_dest_q;
        bus.rsp_id   = rsp_id_q;
        bus.rsp_err  = rsp_err_q;
      end
      default: ;
    endcase
  end

  assign timeout_err = terr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q     <= LW'(NUM_REQ - 1);
      owner_q    <= '0;
      iss_data_q <= '0;
      iss_dest_q <= '0;
      iss_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_dest_q <= '0;
      rsp_id_q   <= '0;
      rsp_err_q  <= 1'b0;
      cnt_q      <= '0;
      terr_q     <= 1'b0;
    end else begin
      if (accept) begin
        last_q     <= win;
        owner_q    <= win;
        iss_data_q <= sel_data;
        iss_dest_q <= sel_dest;
        iss_id_q   <= sel_id;
      end
      if (issue_hs)
        cnt_q <= '0;
      else if (state_q == S_WAIT)
        cnt_q <= cnt_q + 1'b1;
      if (pe_hit) begin
        rsp_data_q <= bus.pe_outp_data;
        rsp_dest_q <= bus.pe_outp_dest;
        rsp_id_q   <= bus.pe_outp_id;
        rsp_err_q  <= 1'b0;
      end else if (expire) begin
        rsp_data_q <= '0;
        rsp_dest_q <= iss_dest_q;
        rsp_id_q   <= iss_id_q;
        rsp_err_q  <= 1'b1;
      end
      if (expire)       terr_q <= 1'b1;
      else if (err_clr) terr_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_koios_pe_arbiter.sv
// Directed bench for koios_pe_arbiter (4 requesters, 128-bit, watchdog 8).
// Each task drives one scenario and checks hand-computed values inline.
module tb_koios_pe_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic err_clr;
  logic busy;
  logic timeout_err;
  int   checks = 0;
  int   errors = 0;

  koios_pe_arbiter_if #(.NUM_REQ(4), .AXI_DATAW(128)) bus ();

  koios_pe_arbiter #(
    .NUM_REQ(4),
    .AXI_DATAW(128),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus),
    .busy(busy),
    .timeout_err(timeout_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    bus.req_data      = '0;
    bus.req_valid     = '0;
    bus.req_dest      = '0;
    bus.req_id        = '0;
    bus.rsp_ready     = '0;
    bus.pe_inp_ready  = 1'b0;
    bus.pe_outp_data  = '0;
    bus.pe_outp_valid = 1'b0;
    bus.pe_outp_dest  = '0;
    bus.pe_outp_id    = '0;
    err_clr           = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [127:0] d,
                         input logic [3:0] de, input logic [1:0] id);
    bus.req_data[i*128 +: 128] = d;
    bus.req_dest[i*4 +: 4]     = de;
    bus.req_id[i*2 +: 2]       = id;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr_inputs();
    repeat (2) step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr_inputs();
    repeat (2) step();
    checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL rst_req_ready got %b want 0000", bus.req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (bus.pe_inp_valid !== 1'b0) begin errors++; $display("FAIL rst_pe_inp_valid got %b want 0", bus.pe_inp_valid); end
    checks++; if (bus.pe_outp_ready !== 1'b0) begin errors++; $display("FAIL rst_pe_outp_ready got %b want 0", bus.pe_outp_ready); end
    checks++; if (bus.rsp_valid !== 4'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0000", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 128'h0) begin errors++; $display("FAIL rst_rsp_data got %h want 0", bus.rsp_data); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err got %b want 0", timeout_err); end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single();
    logic [127:0] aa;
    aa = {16{8'hAA}};
    set_req(0, aa, 4'd3, 2'd1);
    bus.req_valid = 4'b0001;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL t1_req_ready got %b want 0001", bus.req_ready); end
    step();
    bus.req_valid = 4'b0000;
    checks++; if (bus.pe_inp_valid !== 1'b1) begin errors++; $display("FAIL t1_pe_inp_valid got %b want 1", bus.pe_inp_valid); end
    checks++; if (bus.pe_inp_data !== aa) begin errors++; $display("FAIL t1_pe_inp_data got %h want %h", bus.pe_inp_data, aa); end
    checks++; if ({bus.pe_inp_dest, bus.pe_inp_id} !== {4'd3, 2'd1}) begin errors++; $display("FAIL t1_pe_inp_dest_id got %h/%h want 3/1", bus.pe_inp_dest, bus.pe_inp_id); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy got %b want 1", busy); end
    bus.pe_inp_ready = 1'b1;
    step();
    bus.pe_inp_ready = 1'b0;
    checks++; if ({bus.pe_inp_valid, bus.pe_outp_ready} !== 2'b01) begin errors++; $display("FAIL t1_wait_flags got %b want 01", {bus.pe_inp_valid, bus.pe_outp_ready}); end
    repeat (6) step();
    bus.pe_outp_valid = 1'b1;
    bus.pe_outp_data  = 128'h55;
    bus.pe_outp_dest  = 4'd5;
    bus.pe_outp_id    = 2'd2;
    step();
    bus.pe_outp_valid = 1'b0;
    checks++; if (bus.rsp_valid !== 4'b0001) begin errors++; $display("FAIL t1_rsp_valid got %b want 0001", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 128'h55) begin errors++; $display("FAIL t1_rsp_data got %h want 55", bus.rsp_data); end
    checks++; if ({bus.rsp_dest, bus.rsp_id, bus.rsp_err} !== {4'd5, 2'd2, 1'b0}) begin errors++; $display("FAIL t1_rsp_meta got %h/%h/%b want 5/2/0", bus.rsp_dest, bus.rsp_id, bus.rsp_err); end
    bus.rsp_ready = 4'b0001;
    step();
    bus.rsp_ready = 4'b0000;
    checks++; if ({busy, bus.rsp_valid} !== 5'b0) begin errors++; $display("FAIL t1_done got %b want 00000", {busy, bus.rsp_valid}); end
  endtask

  task automatic test_round_robin();
    logic [3:0] ex;
    int e;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 128'(32'hC0 + i), 4'(i), 2'(i));
    bus.req_valid     = 4'hF;
    bus.pe_inp_ready  = 1'b1;
    bus.pe_outp_valid = 1'b1;
    bus.rsp_ready     = 4'hF;
    #1;
    for (int t = 0; t < 8; t++) begin
      e  = t % 4;
      ex = 4'b0001 << e;
      checks++; if (bus.req_ready !== ex) begin errors++; $display("FAIL t2_grant%0d got %b want %b", t, bus.req_ready, ex); end
      step();
      checks++; if (bus.pe_inp_data !== 128'(32'hC0 + e) || bus.req_ready !== 4'b0) begin errors++; $display("FAIL t2_issue%0d got %h/%b want %h/0000", t, bus.pe_inp_data, bus.req_ready, 32'hC0 + e); end
      bus.pe_outp_data = 128'(32'h900 + t);
      step();
      step();
      checks++; if (bus.rsp_valid !== ex || bus.rsp_data !== 128'(32'h900 + t)) begin errors++; $display("FAIL t2_rsp%0d got %b/%h want %b/%h", t, bus.rsp_valid, bus.rsp_data, ex, 32'h900 + t); end
      step();
    end
    clr_inputs();
    #1;
  endtask

  task automatic test_backpressure();
    logic [127:0] d1;
    d1 = {4{32'hB1B1_0001}};
    set_req(1, d1, 4'd7, 2'd3);
    bus.req_valid = 4'b0010;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL t3_grant got %b want 0010", bus.req_ready); end
    step();
    bus.req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.pe_inp_valid !== 1'b1 || bus.pe_inp_data !== d1 || bus.pe_inp_dest !== 4'd7 || bus.pe_inp_id !== 2'd3 || bus.req_ready !== 4'b0) begin errors++; $display("FAIL t3_issue_hold%0d got %b/%h/%h/%h/%b want 1/%h/7/3/0000", i, bus.pe_inp_valid, bus.pe_inp_data, bus.pe_inp_dest, bus.pe_inp_id, bus.req_ready, d1); end
      step();
    end
    bus.pe_inp_ready = 1'b1;
    step();
    bus.pe_inp_ready  = 1'b0;
    bus.pe_outp_valid = 1'b1;
    bus.pe_outp_data  = 128'hDEAD;
    bus.pe_outp_dest  = 4'd4;
    bus.pe_outp_id    = 2'd1;
    #1;
    checks++; if (bus.pe_inp_valid !== 1'b0) begin errors++; $display("FAIL t3_inp_drop got %b want 0", bus.pe_inp_valid); end
    step();
    bus.pe_outp_valid = 1'b0;
    bus.pe_outp_data  = '0;
    bus.pe_outp_dest  = '0;
    bus.pe_outp_id    = '0;
    for (int i = 0; i < 3; i++) begin
      bus.rsp_ready = 4'b1101;
      #1;
      checks++; if (bus.rsp_valid !== 4'b0010 || bus.rsp_data !== 128'hDEAD || bus.rsp_dest !== 4'd4 || bus.rsp_id !== 2'd1 || bus.req_ready !== 4'b0 || busy !== 1'b1) begin errors++; $display("FAIL t3_rsp_hold%0d got %b/%h/%h/%h/%b/%b want 0010/dead/4/1/0000/1", i, bus.rsp_valid, bus.rsp_data, bus.rsp_dest, bus.rsp_id, bus.req_ready, busy); end
      step();
    end
    bus.rsp_ready = 4'b0010;
    step();
    bus.rsp_ready = 4'b0000;
    #1;
    checks++; if ({busy, bus.req_ready} !== 5'b0_0100) begin errors++; $display("FAIL t3_next_grant got %b want 00100", {busy, bus.req_ready}); end
    bus.req_valid = 4'b0000;
    #1;
  endtask

  task automatic test_watchdog();
    set_req(3, {16{8'hDD}}, 4'hA, 2'd2);
    bus.req_valid = 4'b1000;
    #1;
    checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL t4_grant got %b want 1000", bus.req_ready); end
    step();
    bus.req_valid    = 4'b0000;
    bus.pe_inp_ready = 1'b1;
    step();
    bus.pe_inp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.rsp_valid !== 4'b0 || bus.pe_outp_ready !== 1'b1) begin errors++; $display("FAIL t4_wait%0d got %b/%b want 0000/1", i, bus.rsp_valid, bus.pe_outp_ready); end
      step();
    end
    checks++; if (bus.rsp_valid !== 4'b1000 || bus.rsp_data !== 128'h0 || bus.rsp_err !== 1'b1) begin errors++; $display("FAIL t4_abort got %b/%h/%b want 1000/0/1", bus.rsp_valid, bus.rsp_data, bus.rsp_err); end
    checks++; if ({bus.rsp_dest, bus.rsp_id, timeout_err} !== {4'hA, 2'd2, 1'b1}) begin errors++; $display("FAIL t4_abort_meta got %h/%h/%b want a/2/1", bus.rsp_dest, bus.rsp_id, timeout_err); end
    bus.rsp_ready = 4'b1000;
    step();
    bus.rsp_ready = 4'b0000;
    checks++; if ({busy, timeout_err} !== 2'b01) begin errors++; $display("FAIL t4_sticky got %b want 01", {busy, timeout_err}); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL t4_clear got %b want 0", timeout_err); end
    set_req(0, 128'h1234, 4'd6, 2'd0);
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid    = 4'b0000;
    bus.pe_inp_ready = 1'b1;
    step();
    bus.pe_inp_ready = 1'b0;
    repeat (7) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_dest, timeout_err} !== {4'b0001, 1'b1, 4'd6, 1'b1}) begin errors++; $display("FAIL t4_set_wins got %b/%b/%h/%b want 0001/1/6/1", bus.rsp_valid, bus.rsp_err, bus.rsp_dest, timeout_err); end
    bus.rsp_ready = 4'b0001;
    step();
    bus.rsp_ready = 4'b0000;
  endtask

  task automatic test_expiry_tie();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL t5_pre_clear got %b want 0", timeout_err); end
    set_req(1, 128'h4321, 4'd8, 2'd1);
    bus.req_valid = 4'b0010;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL t5_grant got %b want 0010", bus.req_ready); end
    step();
    bus.req_valid    = 4'b0000;
    bus.pe_inp_ready = 1'b1;
    step();
    bus.pe_inp_ready = 1'b0;
    repeat (7) step();
    bus.pe_outp_valid = 1'b1;
    bus.pe_outp_data  = 128'h77;
    bus.pe_outp_dest  = 4'd9;
    bus.pe_outp_id    = 2'd3;
    step();
    bus.pe_outp_valid = 1'b0;
    checks++; if (bus.rsp_valid !== 4'b0010 || bus.rsp_data !== 128'h77 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL t5_rsp got %b/%h/%b want 0010/77/0", bus.rsp_valid, bus.rsp_data, bus.rsp_err); end
    checks++; if ({bus.rsp_dest, bus.rsp_id, timeout_err} !== {4'd9, 2'd3, 1'b0}) begin errors++; $display("FAIL t5_meta got %h/%h/%b want 9/3/0", bus.rsp_dest, bus.rsp_id, timeout_err); end
    bus.rsp_ready = 4'b0010;
    step();
    bus.rsp_ready = 4'b0000;
  endtask

  task automatic test_reset_in_wait();
    logic [127:0] ee;
    ee = {16{8'hEE}};
    set_req(0, 128'h99, 4'd1, 2'd1);
    bus.req_valid = 4'b0001;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL t6_grant0 got %b want 0001", bus.req_ready); end
    step();
    bus.req_valid    = 4'b0000;
    bus.pe_inp_ready = 1'b1;
    step();
    bus.pe_inp_ready = 1'b0;
    step();
    checks++; if ({busy, bus.pe_outp_ready} !== 2'b11) begin errors++; $display("FAIL t6_in_wait got %b want 11", {busy, bus.pe_outp_ready}); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, bus.pe_outp_ready, bus.pe_inp_valid, timeout_err} !== 4'b0) begin errors++; $display("FAIL t6_async_flags got %b want 0000", {busy, bus.pe_outp_ready, bus.pe_inp_valid, timeout_err}); end
    checks++; if (bus.rsp_valid !== 4'b0 || bus.req_ready !== 4'b0 || bus.rsp_data !== 128'h0) begin errors++; $display("FAIL t6_async_bus got %b/%b/%h want 0000/0000/0", bus.rsp_valid, bus.req_ready, bus.rsp_data); end
    step();
    rst_n = 1'b1;
    #1;
    set_req(2, ee, 4'd2, 2'd1);
    bus.req_valid = 4'b0100;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL t6_grant2 got %b want 0100", bus.req_ready); end
    step();
    bus.req_valid = 4'b0000;
    checks++; if (bus.pe_inp_valid !== 1'b1 || bus.pe_inp_data !== ee) begin errors++; $display("FAIL t6_issue got %b/%h want 1/%h", bus.pe_inp_valid, bus.pe_inp_data, ee); end
    bus.pe_inp_ready = 1'b1;
    step();
    bus.pe_inp_ready  = 1'b0;
    bus.pe_outp_valid = 1'b1;
    bus.pe_outp_data  = 128'h31;
    bus.pe_outp_dest  = 4'd1;
    bus.pe_outp_id    = 2'd0;
    step();
    bus.pe_outp_valid = 1'b0;
    checks++; if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== 128'h31 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL t6_rsp got %b/%h/%b want 0100/31/0", bus.rsp_valid, bus.rsp_data, bus.rsp_err); end
    bus.rsp_ready = 4'b0100;
    step();
    bus.rsp_ready = 4'b0000;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_done got %b want 0", busy); end
  endtask

  initial begin
    rst_n = 1'b0;
    clr_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_watchdog();
    test_expiry_tie();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/koios_pe_arbiter.md
# koios_pe_arbiter

- Shares one Koios proxy-PE AXI wrapper between `NUM_REQ` AXI-stream requesters.
- Grants one requester at a time in round-robin order and forwards its beat to the PE.
- Waits for the PE result and routes it back to the owning requester, with a watchdog that aborts a hung transaction.
- Sits between the on-chip NoC adapters and the single PE wrapper instance; exactly one transaction is outstanding at the PE at any time.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `AXI_DATAW`, 128: beat width.
- `TIMEOUT_CYC`, 64: maximum number of WAIT cycles before abort, ≥2.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- Requester-side request inputs:
  - `req_data` in `NUM_REQ*AXI_DATAW`: request payloads, requester i at `[i*AXI_DATAW +: AXI_DATAW]`.
  - `req_valid` in `NUM_REQ`: per-requester valid.
  - `req_dest` in `NUM_REQ*4`: per-requester destination.
  - `req_id` in `NUM_REQ*2`: per-requester transaction id.
- `req_ready` out `NUM_REQ`: one-hot or zero accept.
- Requester-side response outputs:
  - `rsp_data` out `AXI_DATAW`: shared response payload.
  - `rsp_valid` out `NUM_REQ`: one-hot or zero response valid.
  - `rsp_dest` out 4: shared response destination.
  - `rsp_id` out 2: shared response id.
  - `rsp_err` out 1: shared response error flag.
- `rsp_ready` in `NUM_REQ`: per-requester response ready.
- PE-side request outputs: `pe_inp_data` out `AXI_DATAW`, `pe_inp_valid` out 1, `pe_inp_dest` out 4, `pe_inp_id` out 2.
- `pe_inp_ready` in 1: PE accepts request.
- PE-side result inputs: `pe_outp_data` in `AXI_DATAW`, `pe_outp_valid` in 1, `pe_outp_dest` in 4, `pe_outp_id` in 2.
- `pe_outp_ready` out 1: arbiter accepts PE result.
- Status:
  - `busy` out 1: high whenever state ≠ IDLE.
  - `timeout_err` out 1: sticky watchdog flag.
  - `err_clr` in 1: synchronous clear of `timeout_err`.

## Operation

- FSM states:
  - IDLE: any `req_valid` → ARB-accept, go to ISSUE.
  - ISSUE: `pe_inp_ready` → WAIT.
  - WAIT: on `pe_outp_valid`, or when the watchdog expires → RETURN.
  - RETURN: `rsp_ready[owner]` → IDLE.
- Round-robin arbitration:
  - Search starts at `(last_grant+1) mod NUM_REQ` and picks the first asserted `req_valid`.
  - `req_ready[winner]` is asserted combinationally in IDLE only; all other bits are 0.
  - Handshake on `req_valid[w] && req_ready[w]`:
    - Capture data, dest and id into the issue registers.
    - Set `owner=w` and `last_grant=w`.
- ISSUE:
  - `pe_inp_valid=1` and `pe_inp_*` are driven from the issue registers, stable until `pe_inp_ready`.
  - On `pe_inp_valid && pe_inp_ready`, drop `pe_inp_valid` and clear the watchdog counter.
- WAIT:
  - `pe_outp_ready=1` for the whole state.
  - On `pe_outp_valid`, capture `pe_outp_data`, `pe_outp_dest` and `pe_outp_id` into the `rsp_*` registers with `rsp_err=0`.
  - The counter increments every WAIT cycle. If it reaches `TIMEOUT_CYC-1` without `pe_outp_valid`:
    - Load `rsp_data=0`, `rsp_dest` = issued dest, `rsp_id` = issued id, `rsp_err=1`.
    - Set `timeout_err`.
    - Go to RETURN.
  - `pe_outp_valid` on the expiry cycle wins: normal capture with `rsp_err=0`.
- RETURN:
  - `rsp_valid[owner]=1`; the `rsp_*` outputs are held stable until `rsp_ready[owner]`.
  - Other `rsp_ready` bits are ignored.
  - A stray `pe_outp_valid` outside WAIT is dropped, since `pe_outp_ready=0`.
- `timeout_err`:
  - Set by watchdog expiry.
  - Cleared by `err_clr` on the next edge.
  - Set wins over clear when both occur in the same cycle.
- Reset values:
  - `last_grant = NUM_REQ-1`, so requester 0 has first priority.
  - State is IDLE; counters are 0.
  - All outputs are 0, including `req_ready`, `busy`, `pe_inp_*`, `pe_outp_ready`, `rsp_*` and `timeout_err`.
- Reset mid-operation: the transaction is abandoned and no response is produced. All outputs go to 0 asynchronously.

## Timing

- Request accepted at edge T (in IDLE) → `pe_inp_valid` is high in cycle T+1.
- PE accepts at edge T+1 → WAIT from T+2.
- PE result at edge R → `rsp_valid[owner]` is high in cycle R+1.
- Response consumed at edge C → IDLE in cycle C+1. A new grant is possible in that cycle, so there is 1 idle cycle between transactions.
- Minimum transaction: 4 cycles plus PE latency.
- The watchdog aborts at WAIT cycle `TIMEOUT_CYC`, i.e. RETURN in the following cycle.
- No combinational path from `pe_*` inputs to `req_*` or `rsp_*` outputs. `req_ready` depends combinationally only on `req_valid`, state and `last_grant`.

## Test plan

1. **Single requester.** After reset, requester 0 sends a beat with data 0x…AA, dest 3, id 1. The PE returns data 0x55 with dest 5 and id 2 after 7 cycles. Required: `pe_inp_valid` is high 1 cycle after acceptance; `rsp_valid=4'b0001` with the PE's data, dest 5, id 2 and `rsp_err=0`.
2. **Round-robin fairness.** All 4 `req_valid` are held high for 8 transactions. Required: grant order is 0,1,2,3,0,1,2,3 and `req_ready` is never multi-hot.
3. **Backpressure.** Hold `pe_inp_ready=0` for 5 cycles, then hold `rsp_ready=0` for 3 cycles. Required: `pe_inp_*` and `rsp_*` are stable throughout, and no second grant occurs while `busy=1`.
4. **Watchdog expiry.** `TIMEOUT_CYC=8` and the PE never responds. Required: `rsp_valid[owner]` with `rsp_data=0` and `rsp_err=1`, `timeout_err=1`. Then `err_clr` clears it; `err_clr` in the same cycle as a new expiry leaves it at 1.
5. **Expiry tie.** `pe_outp_valid` arrives exactly on the expiry cycle. Required: normal response with `rsp_err=0` and `timeout_err` unchanged.
6. **Reset in WAIT.** Pulse `reset` low while in WAIT. Required: all outputs are 0 immediately, and the next request from requester 2 is the first grant with normal flow.
